// File: rtl/mips_pkg.sv
// Shared constants for the MIPS-style pipeline front end.
// Also provides the word-alignment helper used on redirect targets.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'd4;

    // Redirect targets are silently word-aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register with a flush (clear) and a hold (stall) control.
// Clear wins over hold; otherwise new data is captured and marked valid.
module ifid_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        clear,
    input  logic [31:0] d_instruction,
    input  logic [31:0] d_pc_plus4,
    output logic [31:0] q_instruction,
    output logic [31:0] q_pc_plus4,
    output logic        q_valid
);

    logic [31:0] instruction_q, instruction_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instruction_d = instruction_q;
        pc_plus4_d    = pc_plus4_q;
        valid_d       = valid_q;
        if (clear) begin
            // The bubble keeps its stale pc_plus4; only valid and the nop matter.
            instruction_d = NOP_INSTR;
            valid_d       = 1'b0;
        end else if (!hold) begin
            instruction_d = d_instruction;
            pc_plus4_d    = d_pc_plus4;
            valid_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction_q <= NOP_INSTR;
            pc_plus4_q    <= 32'h0;
            valid_q       <= 1'b0;
        end else begin
            instruction_q <= instruction_d;
            pc_plus4_q    <= pc_plus4_d;
            valid_q       <= valid_d;
        end
    end

    assign q_instruction = instruction_q;
    assign q_pc_plus4    = pc_plus4_q;
    assign q_valid       = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, selects the next PC and loads IF/ID.
// Branch (older, from EX) beats jump (from ID), and both beat a decode stall.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          COUNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_stall,
    input  logic               if_branch_taken,
    input  logic [31:0]        if_branch_target,
    input  logic               if_jump,
    input  logic [31:0]        if_jump_target,
    output logic [31:0]        imem_pc,
    input  logic [31:0]        imem_instruction,
    output logic [31:0]        ifid_instruction,
    output logic [31:0]        ifid_pc_plus4,
    output logic               ifid_valid,
    output logic               if_redirect,
    output logic [COUNT_W-1:0] if_fetch_count
);

    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [31:0]        pc_q, pc_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [31:0]        pc_plus4;
    logic               redirect;
    logic               fetch;

    assign pc_plus4 = pc_q + PC_STEP;
    assign redirect = if_branch_taken | if_jump;
    assign fetch    = !redirect && !if_stall;

    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        if (if_branch_taken) begin
            pc_d = align_word(if_branch_target);
        end else if (if_jump) begin
            pc_d = align_word(if_jump_target);
        end else if (fetch) begin
            pc_d    = pc_plus4;
            count_d = count_q + COUNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    ifid_reg u_ifid_reg (
        .clk           (clk),
        .rst           (rst),
        .hold          (if_stall),
        .clear         (redirect),
        .d_instruction (imem_instruction),
        .d_pc_plus4    (pc_plus4),
        .q_instruction (ifid_instruction),
        .q_pc_plus4    (ifid_pc_plus4),
        .q_valid       (ifid_valid)
    );

    assign imem_pc        = pc_q;
    assign if_redirect    = redirect;
    assign if_fetch_count = count_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives it onto imem_pc.
- Takes the combinational instruction returned on imem_instruction and registers it, with its PC+4 and a valid bit, into the IF/ID pipeline register that feeds decode.
- Handles decode stalls, branch and jump redirects, and wrong-path flush.

Parameters:
- RESET_PC, 32'd4: PC loaded on reset. The program image starts at byte address 4.
- COUNT_W, 16: width of the fetched-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_stall  input  1  hazard unit requests that PC and IF/ID hold.
- if_branch_taken  input  1  EX-stage branch resolved taken this cycle.
- if_branch_target  input  32  branch target address.
- if_jump  input  1  ID-stage jump decoded this cycle.
- if_jump_target  input  32  jump target address.
- imem_pc  output  32  address to instruction memory; equals the PC register.
- imem_instruction  input  32  instruction at imem_pc, combinational and valid in the same cycle.
- ifid_instruction  output  32  registered instruction to decode.
- ifid_pc_plus4  output  32  registered PC+4 of that instruction.
- ifid_valid  output  1  IF/ID holds a real instruction.
- if_redirect  output  1  combinational; high when a branch or jump redirect is taken this cycle. Used by the ID/EX flush logic.
- if_fetch_count  output  COUNT_W  number of instructions delivered to IF/ID.

Behaviour:
- Reset (asynchronous, active-high; applies immediately, including mid-stall or mid-redirect):
  - pc = RESET_PC
  - ifid_instruction = 32'h0 (nop)
  - ifid_pc_plus4 = 0
  - ifid_valid = 0
  - if_fetch_count = 0
- imem_pc = pc at all times. No extra latency: the instruction for pc is sampled at the same rising edge.
- pc_plus4 = pc + 4, 32-bit modulo. 0xFFFFFFFC wraps to 0x00000000.
- Redirect targets: bits [1:0] are forced to 0 before loading pc. Misaligned targets are silently word-aligned.
- Next-state priority, evaluated each rising edge (highest first):
  1. if_branch_taken: pc <= branch_target; ifid_valid <= 0; ifid_instruction <= 0. The branch is older than the jump, so it wins over a simultaneous if_jump.
  2. if_jump: pc <= jump_target; ifid_valid <= 0; ifid_instruction <= 0.
  3. if_stall: pc, ifid_instruction, ifid_pc_plus4, ifid_valid and if_fetch_count all hold.
  4. Otherwise (normal fetch): pc <= pc_plus4; ifid_instruction <= imem_instruction; ifid_pc_plus4 <= pc_plus4; ifid_valid <= 1; if_fetch_count increments.
- Redirects override if_stall. A stall asserted together with a redirect is ignored for that cycle.
- if_redirect = if_branch_taken | if_jump, purely combinational.
- if_fetch_count increments only on a normal fetch and wraps modulo 2^COUNT_W.
- Redirect latency: the target instruction appears in IF/ID one cycle after the redirect edge. Exactly one bubble (ifid_valid = 0) is inserted.
- Redirect to the current pc is legal and still inserts one bubble.
- An X or unknown imem_instruction is passed through unchanged. The stage does not interpret instruction contents.

Decomposition:
- Shared package (mips_pkg): NOP_INSTR = 32'h0, the PC_STEP = 4 constant, and the RESET_PC default.
- One natural sub-module: ifid_reg, the IF/ID pipeline register with hold (stall) and clear (flush) controls, reusable for later pipeline registers.
- PC, next-PC mux and counter stay in if_stage.

Test Plan:
- Reset then 3 free-running cycles with memory words A, B, C at addresses 4, 8, 12:
  - imem_pc goes 4 → 8 → 12 → 16.
  - ifid_instruction goes A, B, C; ifid_pc_plus4 goes 8, 12, 16.
  - ifid_valid = 1 after the first edge; count = 3.
- if_stall high for 2 cycles while pc = 12:
  - imem_pc stays 12; IF/ID holds; count unchanged.
  - After release, the next edge loads instruction@12 with pc_plus4 = 16.
- if_jump with target 0x8D (misaligned) at pc = 40:
  - pc becomes 0x8C; ifid_valid = 0 for one cycle.
  - Next edge loads instruction@0x8C; count does not increment on the redirect edge.
- if_branch_taken (target 136) and if_jump (target 4) together, plus if_stall:
  - pc becomes 136; if_redirect = 1; ifid_valid = 0.
- Wrap: force pc = 0xFFFFFFFC via redirect, then one normal fetch:
  - pc becomes 0x00000000; ifid_pc_plus4 = 0.
- Assert rst asynchronously mid-stall, between clock edges:
  - Outputs immediately show pc = 4, ifid_valid = 0, ifid_instruction = 0, count = 0.
  - Normal fetch resumes on the first edge after rst deasserts.
